// File: rtl/multicycle_alu_controller.sv
// Control FSM for a multicycle RV32I subset (ADD, ADDI, LUI, LW, SW).
// Drives the datapath selects and strobes, counts retired instructions, and traps on bad opcodes or memory timeouts.
// Latency: 4 cycles for ADD/ADDI/LUI/SW and 5 for LW; each memory wait cycle adds one.
module multicycle_alu_controller #(
  parameter int COUNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             Opcode_i,
  input  logic [2:0]             Funct3_i,
  input  logic [6:0]             Funct7_i,
  input  logic                   Mem_Ready_i,
  output logic                   PC_Write_o,
  output logic                   IR_Write_o,
  output logic                   IorD_o,
  output logic                   Mem_Read_o,
  output logic                   Mem_Write_o,
  output logic [1:0]             ALU_Src_A_o,
  output logic [1:0]             ALU_Src_B_o,
  output logic [3:0]             ALU_Operation_o,
  output logic                   Reg_Write_o,
  output logic                   Mem_to_Reg_o,
  output logic                   Illegal_o,
  output logic [3:0]             State_o,
  output logic [COUNT_WIDTH-1:0] Instr_Count_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_EXEC_LUI = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WB   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_ALU_WB   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // The wait counter only has to reach MEM_TIMEOUT-1: the cycle after that either traps or changes state.
  localparam int              WAIT_WIDTH = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]             state_q, state_d;
  logic [WAIT_WIDTH-1:0]  wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   illegal_q, illegal_d;
  logic                   in_wait, timeout, retire;

  // Memory-wait states; the timeout fires only when ready is absent, so a late ready always wins.
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = TIMEOUT_EN && in_wait && !Mem_Ready_i && (wait_q == WAIT_LAST);
  assign retire  = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                   ((state_q == S_MEM_WR) && Mem_Ready_i);

  // State register plus wait counter, retire counter and sticky trap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state decode, with the memory timeout overriding any stay-in-place decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (Mem_Ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (Opcode_i == OP_R && Funct3_i == 3'b000 && Funct7_i == 7'b0000000) state_d = S_EXEC_R;
        else if (Opcode_i == OP_I && Funct3_i == 3'b000)                     state_d = S_EXEC_I;
        else if (Opcode_i == OP_LUI)                                         state_d = S_EXEC_LUI;
        else if (Opcode_i == OP_LOAD && Funct3_i == 3'b010)                  state_d = S_MEM_ADDR;
        else if (Opcode_i == OP_STORE && Funct3_i == 3'b010)                 state_d = S_MEM_ADDR;
        else                                                                 state_d = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (Opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (Mem_Ready_i) state_d = S_MEM_WB;
      S_MEM_WR:   if (Mem_Ready_i) state_d = S_FETCH;
      S_MEM_WB, S_ALU_WB: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  // Counter updates: wait count restarts on every state change, retire count wraps freely.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)          wait_d = '0;
    else if (in_wait && !Mem_Ready_i) wait_d = wait_q + WAIT_WIDTH'(1);
    count_d   = retire ? count_q + COUNT_WIDTH'(1) : count_q;
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Datapath controls per state; reset masks every strobe so nothing is written mid-reset.
  always_comb begin
    PC_Write_o      = 1'b0;
    IR_Write_o      = 1'b0;
    IorD_o          = 1'b0;
    Mem_Read_o      = 1'b0;
    Mem_Write_o     = 1'b0;
    ALU_Src_A_o     = 2'b00;
    ALU_Src_B_o     = 2'b00;
    ALU_Operation_o = ALU_ADD;
    Reg_Write_o     = 1'b0;
    Mem_to_Reg_o    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = 2'b01;
        PC_Write_o  = Mem_Ready_i;
        IR_Write_o  = Mem_Ready_i;
      end
      S_EXEC_R:   ALU_Src_A_o = 2'b01;
      S_EXEC_I, S_MEM_ADDR: begin
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b10;
      end
      S_EXEC_LUI: begin
        ALU_Src_B_o     = 2'b10;
        ALU_Operation_o = ALU_LUI;
      end
      S_MEM_RD: begin
        Mem_Read_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_MEM_WR: begin
        Mem_Write_o = 1'b1;
        IorD_o      = 1'b1;
      end
      S_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 1'b1;
      end
      S_ALU_WB:   Reg_Write_o = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PC_Write_o  = 1'b0;
      IR_Write_o  = 1'b0;
      Mem_Read_o  = 1'b0;
      Mem_Write_o = 1'b0;
      Reg_Write_o = 1'b0;
    end
  end

  assign Illegal_o     = illegal_q;
  assign State_o       = state_q;
  assign Instr_Count_o = count_q;

endmodule

// File: tb/tb_multicycle_alu_controller.sv
// Bench for multicycle_alu_controller: instruction-level reference model builds the expected per-cycle trace.
// Each instruction expands into a queue of (state, ready, retire) entries checked cycle by cycle.
// Small COUNT_WIDTH exercises counter wrap; MEM_TIMEOUT = 4 exercises the timeout boundary.
module tb_multicycle_alu_controller;
  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'b0;
  logic [2:0]    funct3 = 3'b0;
  logic [6:0]    funct7 = 7'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, illegal;
  logic [1:0]    src_a, src_b;
  logic [3:0]    alu_op, state;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt;

  int q_state[$];
  bit q_rdy[$];
  bit q_ret[$];

  multicycle_alu_controller #(.COUNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Opcode_i(opcode), .Funct3_i(funct3), .Funct7_i(funct7), .Mem_Ready_i(mem_ready),
    .PC_Write_o(pc_write), .IR_Write_o(ir_write), .IorD_o(iord),
    .Mem_Read_o(mem_read), .Mem_Write_o(mem_write),
    .ALU_Src_A_o(src_a), .ALU_Src_B_o(src_b), .ALU_Operation_o(alu_op),
    .Reg_Write_o(reg_write), .Mem_to_Reg_o(mem_to_reg), .Illegal_o(illegal),
    .State_o(state), .Instr_Count_o(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction class from the ISA subset rules: 0 R, 1 ADDI, 2 LUI, 3 LW, 4 SW, 5 illegal.
  function automatic int classify(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
    if (opc == 7'b0110011 && f3 == 3'd0 && f7 == 7'd0) return 0;
    if (opc == 7'b0010011 && f3 == 3'd0)               return 1;
    if (opc == 7'b0110111)                             return 2;
    if (opc == 7'b0000011 && f3 == 3'd2)               return 3;
    if (opc == 7'b0100011 && f3 == 3'd2)               return 4;
    return 5;
  endfunction

  // Control word demanded in each state: {pcw,irw,iord,mrd,mwr,srcA,srcB,op,rw,m2r,ill}.
  function automatic logic [15:0] exp_outs(int st, bit r);
    logic pcw, irw, io, mr, mw, rw, m2r, ill;
    logic [1:0] a, b;
    logic [3:0] op;
    pcw = 0; irw = 0; io = 0; mr = 0; mw = 0; rw = 0; m2r = 0; ill = 0;
    a = 2'b00; b = 2'b00; op = 4'b0000;
    case (st)
      0:  begin mr = 1; b = 2'b01; pcw = r; irw = r; end
      2:  a = 2'b01;
      3:  begin a = 2'b01; b = 2'b10; end
      4:  begin b = 2'b10; op = 4'b1000; end
      5:  begin a = 2'b01; b = 2'b10; end
      6:  begin mr = 1; io = 1; end
      7:  begin rw = 1; m2r = 1; end
      8:  begin mw = 1; io = 1; end
      9:  rw = 1;
      10: ill = 1;
      default: ;
    endcase
    return {pcw, irw, io, mr, mw, a, b, op, rw, m2r, ill};
  endfunction

  function automatic logic [15:0] dut_outs();
    return {pc_write, ir_write, iord, mem_read, mem_write, src_a, src_b, alu_op,
            reg_write, mem_to_reg, illegal};
  endfunction

  function automatic void push(int st, bit r, bit ret);
    q_state.push_back(st);
    q_rdy.push_back(r);
    q_ret.push_back(ret);
  endfunction

  // A memory phase with 'waits' not-ready cycles; returns 1 when it runs into the timeout.
  function automatic bit push_mem(int st, int waits, bit ret_on_ready);
    for (int i = 0; i < waits && i < TO; i++) push(st, 1'b0, 1'b0);
    if (waits >= TO) begin
      push(10, 1'($urandom_range(0, 1)), 1'b0);
      return 1'b1;
    end
    push(st, 1'b1, ret_on_ready);
    return 1'b0;
  endfunction

  // Called just after a negedge; every cycle drives ready, then samples 1 time unit later.
  task automatic run_queue();
    int st;
    bit r, ret;
    while (q_state.size() > 0) begin
      st  = q_state.pop_front();
      r   = q_rdy.pop_front();
      ret = q_ret.pop_front();
      mem_ready = r;
      #1;
      check("state", 32'(state), 32'(st));
      check("outputs", 32'(dut_outs()), 32'(exp_outs(st, r)));
      check("count", 32'(instr_count), 32'(exp_cnt));
      if (ret) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input int wf, input int wm, output bit trapped);
    opcode = opc; funct3 = f3; funct7 = f7;
    trapped = push_mem(0, wf, 1'b0);
    if (!trapped) begin
      push(1, 1'($urandom_range(0, 1)), 1'b0);
      case (classify(opc, f3, f7))
        0: begin push(2, 1'($urandom_range(0, 1)), 0); push(9, 1'($urandom_range(0, 1)), 1); end
        1: begin push(3, 1'($urandom_range(0, 1)), 0); push(9, 1'($urandom_range(0, 1)), 1); end
        2: begin push(4, 1'($urandom_range(0, 1)), 0); push(9, 1'($urandom_range(0, 1)), 1); end
        3: begin
          push(5, 1'($urandom_range(0, 1)), 0);
          trapped = push_mem(6, wm, 1'b0);
          if (!trapped) push(7, 1'($urandom_range(0, 1)), 1);
        end
        4: begin
          push(5, 1'($urandom_range(0, 1)), 0);
          trapped = push_mem(8, wm, 1'b1);
        end
        default: begin push(10, 1'($urandom_range(0, 1)), 0); trapped = 1'b1; end
      endcase
    end
    // TRAP must hold regardless of ready.
    if (trapped) begin
      push(10, 1'b1, 0);
      push(10, 1'b0, 0);
    end
    run_queue();
  endtask

  // Entered and left at a negedge; leaves reset low with the DUT in FETCH.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_strobes_async", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    bit trapped;
    int cls;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    exp_cnt = '0;
    @(negedge clk);
    do_reset();

    // Directed: ADD, LUI, ADDI, LW with 3 waits, SW, LW with 3 fetch waits.
    run_instr(7'b0110011, 3'd0, 7'd0, 0, 0, trapped);
    run_instr(7'b0110111, 3'd5, 7'd33, 0, 0, trapped);
    run_instr(7'b0010011, 3'd0, 7'd9, 0, 0, trapped);
    run_instr(7'b0000011, 3'd2, 7'd0, 0, 3, trapped);
    run_instr(7'b0100011, 3'd2, 7'd0, 0, 0, trapped);
    run_instr(7'b0000011, 3'd2, 7'd0, TO - 1, 0, trapped);
    run_instr(7'b0100011, 3'd2, 7'd0, 1, TO - 1, trapped);

    // Random legal instructions with random (sub-timeout) memory latency; count wraps.
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 4);
      f7  = 7'($urandom);
      f3  = 3'($urandom);
      case (cls)
        0: begin opc = 7'b0110011; f3 = 3'd0; f7 = 7'd0; end
        1: begin opc = 7'b0010011; f3 = 3'd0; end
        2: opc = 7'b0110111;
        3: begin opc = 7'b0000011; f3 = 3'd2; end
        default: begin opc = 7'b0100011; f3 = 3'd2; end
      endcase
      run_instr(opc, f3, f7, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), trapped);
    end

    // SW never acknowledged: trap after TO wait cycles, count unchanged.
    run_instr(7'b0100011, 3'd2, 7'd0, 0, TO, trapped);
    check("sw_timeout_trapped", 32'(trapped), 32'd1);
    do_reset();

    // LW read never acknowledged.
    run_instr(7'b0000011, 3'd2, 7'd0, 2, TO, trapped);
    do_reset();

    // Fetch never acknowledged.
    run_instr(7'b0110011, 3'd0, 7'd0, TO, 0, trapped);
    do_reset();

    // Illegal encodings: SYSTEM opcode, SUB, LB, SH.
    run_instr(7'b1110011, 3'd0, 7'd0, 0, 0, trapped);
    do_reset();
    run_instr(7'b0110011, 3'd0, 7'b0100000, 1, 0, trapped);
    do_reset();
    run_instr(7'b0000011, 3'd0, 7'd0, 0, 0, trapped);
    do_reset();
    run_instr(7'b0100011, 3'd1, 7'd0, 0, 0, trapped);
    do_reset();

    // Normal operation after a trap-clearing reset.
    run_instr(7'b0110011, 3'd0, 7'd0, 0, 0, trapped);
    run_instr(7'b0000011, 3'd2, 7'd0, 0, 0, trapped);
    mem_ready = 1'b0;
    #1;
    check("final_count", 32'(instr_count), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
